// File: rtl/fsm_ringcounter_gen.sv
// Ring / Johnson counter, N bits, with home pattern MSB-only and per-step wrap pulse.
// Optional illegal-state detection and recovery when RINGCNT_ERRCHK_EN is defined.
module fsm_ringcounter_gen #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable_in,
    input  logic         dir_in,
    input  logic         mode_in,
    input  logic         load_in,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] out,
    output logic         wrap_out,
    output logic         err_out
);

    localparam logic [N-1:0] HOME = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_RECOVER,
        ACT_STEP
    } act_e;

    logic [N-1:0] out_q, out_d;
    logic         wrap_q, wrap_d;
    logic         err_q, err_d;
    logic [N-1:0] step_val;
    logic         illegal;
    act_e         act;

`ifdef RINGCNT_ERRCHK_EN
    logic [N-1:0] inv_val;
    logic         one_hot;
    logic         low_run;
    logic         high_run;

    // A run of ones anchored at the LSB has no carry overlap with itself plus one.
    always_comb begin
        inv_val  = ~out_q;
        one_hot  = (out_q != '0) && ((out_q & (out_q - 1'b1)) == '0);
        low_run  = ((out_q & (out_q + 1'b1)) == '0);
        high_run = ((inv_val & (inv_val + 1'b1)) == '0);
        illegal  = mode_in ? !(low_run || high_run) : !one_hot;
    end
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        case ({mode_in, dir_in})
            2'b00:   step_val = {out_q[0], out_q[N-1:1]};
            2'b01:   step_val = {out_q[N-2:0], out_q[N-1]};
            2'b10:   step_val = {~out_q[0], out_q[N-1:1]};
            default: step_val = {out_q[N-2:0], ~out_q[N-1]};
        endcase
    end

    always_comb begin
        act = ACT_HOLD;
        if (load_in)        act = ACT_LOAD;
        else if (illegal)   act = ACT_RECOVER;
        else if (enable_in) act = ACT_STEP;
    end

    always_comb begin
        out_d  = out_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        case (act)
            ACT_LOAD:    out_d = load_val;
            ACT_RECOVER: begin
                out_d = HOME;
                err_d = 1'b1;
            end
            ACT_STEP:    begin
                out_d  = step_val;
                wrap_d = (step_val == HOME);
            end
            default:     out_d = out_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q  <= HOME;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign out      = out_q;
    assign wrap_out = wrap_q;
    assign err_out  = err_q;

endmodule
